// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, cmov/jump condition, and the M pipeline register.
// e_valE/e_dstE/e_Cnd are same-cycle combinational; M outputs are one edge later; the stage never stalls.
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valC,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  input  logic        M_bubble,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic        M_cnd
);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_fun;
  logic [63:0] alu_res;
  logic        alu_of;
  logic        set_cc;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;

  always_comb begin
    alu_a = 64'd0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:               alu_a = 64'd8;
      default:                     alu_a = 64'd0;
    endcase
  end

  always_comb begin
    alu_b = 64'd0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                  alu_b = 64'd0;
    endcase
  end

  assign alu_fun = (E_icode == I_OPQ) ? E_ifun : 4'd0;

  // Overflow follows two's-complement sign rules; logical ops never overflow.
  always_comb begin
    alu_res = 64'd0;
    alu_of  = 1'b0;
    case (alu_fun)
      4'd0: begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
      end
      4'd1: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
      end
      4'd2:    alu_res = alu_b & alu_a;
      4'd3:    alu_res = alu_b ^ alu_a;
      default: alu_res = 64'd0;
    endcase
  end

  assign e_valE = alu_res;

  // Flags freeze while a later stage carries an exception.
  assign set_cc = (E_icode == I_OPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= (alu_res == 64'd0);
      cc_sf <= alu_res[63];
      cc_of <= alu_of;
    end
  end

  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      4'd0:    e_Cnd = 1'b1;
      4'd1:    e_Cnd = (cc_sf ^ cc_of) | cc_zf;
      4'd2:    e_Cnd = cc_sf ^ cc_of;
      4'd3:    e_Cnd = cc_zf;
      4'd4:    e_Cnd = ~cc_zf;
      4'd5:    e_Cnd = ~(cc_sf ^ cc_of);
      4'd6:    e_Cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? REG_NONE : E_dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
      M_valE  <= 64'd0;
      M_valA  <= 64'd0;
      M_cnd   <= 1'b0;
    end else if (M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
      M_valE  <= 64'd0;
      M_valA  <= 64'd0;
      M_cnd   <= 1'b0;
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
      M_valE  <= alu_res;
      M_valA  <= E_valA;
      M_cnd   <= e_Cnd;
    end
  end

endmodule
